hls_deadlock_monitor_param: RTL and testbench
=============================================

Name: hls_deadlock_monitor_param

Overview:
- Parametrised deadlock monitor for one HLS dataflow region with NUM_PROC processes.
- Flags a deadlock only when the stall condition persists for THRESHOLD consecutive cycles:
  - stall condition = at least one process blocked on AXI-Stream, and every process idle, channel-blocked or AXIS-blocked.
- Optionally latches the flag, snapshots which processes were blocked, and counts deadlock events.
- Sits beside the dataflow instance and feeds the top-level deadlock report / debug register path.

Parameters:
- NUM_PROC, 2, number of monitored processes (>=1).
- THRESHOLD, 16, consecutive stall cycles required before declaring deadlock (>=1).
- STICKY, 1, 1 = block held until clear; 0 = block drops when the stall condition drops.
- EVT_W, 8, width of the saturating deadlock event counter.

Ports:
- clock, in, 1, rising-edge clock.
- reset, in, 1, asynchronous active-high reset.
- axis_block_sigs, in, NUM_PROC, bit i = process i blocked on an AXIS port.
- inst_idle_sigs, in, NUM_PROC, bit i = process i idle.
- inst_block_sigs, in, NUM_PROC, bit i = process i blocked on an internal channel.
- clear, in, 1, synchronous pulse; releases a detected deadlock and restarts qualification.
- block, out, 1, registered deadlock flag.
- block_proc_vec, out, NUM_PROC, snapshot of (axis_block_sigs | inst_block_sigs) taken at detection.
- block_axis_vec, out, NUM_PROC, snapshot of axis_block_sigs taken at detection.
- event_count, out, EVT_W, number of detections since reset; saturates at all-ones.

Behaviour:
- Combinational terms:
  - stop_i = idle_i | chan_block_i | axis_block_i.
  - cond = (|axis_block_sigs) & (&stop).
- Stall counter stall_cnt has width $clog2(THRESHOLD+1).
- State machine has states IDLE, ARMED, DETECTED; all transitions occur on the rising clock edge.
- IDLE:
  - cond=1 and THRESHOLD=1 -> DETECTED.
  - cond=1 and THRESHOLD>1 -> ARMED, stall_cnt=1.
  - Otherwise stay, stall_cnt=0.
- ARMED:
  - cond=0 -> IDLE, stall_cnt=0. Any single-cycle break fully restarts qualification.
  - cond=1 and stall_cnt==THRESHOLD-1 -> DETECTED.
  - cond=1 otherwise -> stall_cnt+1.
- Entry into DETECTED:
  - block<=1.
  - Capture block_proc_vec and block_axis_vec from the current-cycle inputs.
  - event_count+1, saturating.
- DETECTED with STICKY=1: stay until clear=1, regardless of cond.
- DETECTED with STICKY=0: cond=0 -> IDLE, block<=0. Snapshots hold their last captured value.
- clear=1:
  - From any state -> IDLE; block<=0; stall_cnt=0.
  - Snapshots and event_count are unchanged.
  - clear has priority over a detection in the same cycle (no capture, no count).
  - cond still 1 on the cycle after clear starts a new qualification from stall_cnt=0.
- Latency: if cond is sampled 1 on edges k .. k+THRESHOLD-1, block is visible after edge k+THRESHOLD-1.
  - THRESHOLD=1 gives the single-cycle registered behaviour of the first-generation monitor.
- Re-detection in STICKY=0 requires a fresh THRESHOLD-cycle run.
- Reset (asynchronous, any time including mid-count):
  - state=IDLE, stall_cnt=0, block=0, block_proc_vec=0, block_axis_vec=0, event_count=0.
- No X propagation: all outputs are registered, none are combinational from inputs.

Decomposition:
- Shared package hls_deadlock_pkg holds:
  - monitor state enum (IDLE, ARMED, DETECTED);
  - counter-width helper function;
  - default THRESHOLD constant.
- One sub-module is natural: hls_deadlock_stall_timer.
  - Inputs: cond, clear.
  - Output: expire pulse.
  - Parameter: THRESHOLD.
  - Wraps stall_cnt.
- The FSM, snapshot registers and event counter stay in the top module.

Test Plan:
- NUM_PROC=2, THRESHOLD=4, STICKY=1: axis=01, idle=10 held 4 cycles -> block=1 after the 4th edge, block_axis_vec=01, block_proc_vec=01, event_count=1.
- Same setup, cond true 3 cycles, 1 cycle false, then 3 true -> block stays 0 and event_count=0.
- STICKY=1: after detection drop cond -> block stays 1. Pulse clear -> block=0 next edge. Hold cond 4 more cycles -> block=1, event_count=2.
- STICKY=0, THRESHOLD=1: axis=11 for 1 cycle -> block=1 one edge later. Cond low -> block=0 next edge. Matches the legacy single-cycle monitor.
- Clear asserted on the same edge as the 4th qualifying cycle -> block stays 0, event_count unchanged, snapshots unchanged.
- EVT_W=2, force 5 detections -> event_count saturates at 3. Assert reset asynchronously mid-ARMED -> all outputs 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/hls_deadlock_pkg.sv
// Shared types and helpers for the HLS dataflow deadlock monitor.
package hls_deadlock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_DETECTED = 2'd2
  } mon_state_e;

  localparam int DEFAULT_THRESHOLD = 16;

  // Width needed to hold stall counts 0..threshold.
  function automatic int stall_cnt_width(input int threshold);
    return (threshold < 1) ? 1 : $clog2(threshold + 1);
  endfunction

endpackage

// File: rtl/hls_deadlock_stall_timer.sv
// Counts consecutive stall cycles and pulses expire on the THRESHOLD-th one.
module hls_deadlock_stall_timer
  import hls_deadlock_pkg::*;
#(
  parameter int THRESHOLD = DEFAULT_THRESHOLD
) (
  input  logic clock,
  input  logic reset,
  input  logic cond,
  input  logic clear,
  output logic expire
);

  localparam int CNT_W = stall_cnt_width(THRESHOLD);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(THRESHOLD - 1);

  logic [CNT_W-1:0] stall_cnt_r;

  // Expire when the current stall cycle completes the run; clear wins.
  always_comb begin
    expire = 1'b0;
    if (cond && !clear && (stall_cnt_r == LAST_CNT)) begin
      expire = 1'b1;
    end else begin
      expire = 1'b0;
    end
  end

  // Any break, clear or expiry restarts qualification from zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (clear || !cond || expire) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hls_deadlock_monitor_param.sv
// Deadlock monitor for one HLS dataflow region: qualifies a persistent stall,
// flags it, snapshots the blocked processes and counts detections.
module hls_deadlock_monitor_param
  import hls_deadlock_pkg::*;
#(
  parameter int NUM_PROC  = 2,
  parameter int THRESHOLD = DEFAULT_THRESHOLD,
  parameter int STICKY    = 1,
  parameter int EVT_W     = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_PROC-1:0] axis_block_sigs,
  input  logic [NUM_PROC-1:0] inst_idle_sigs,
  input  logic [NUM_PROC-1:0] inst_block_sigs,
  input  logic                clear,
  output logic                block,
  output logic [NUM_PROC-1:0] block_proc_vec,
  output logic [NUM_PROC-1:0] block_axis_vec,
  output logic [EVT_W-1:0]    event_count
);

  mon_state_e          state_r;
  logic [NUM_PROC-1:0] stop_s;
  logic                cond_s;
  logic                timer_cond_s;
  logic                expire_s;

  // Stall: someone waits on AXIS and nobody is making forward progress.
  always_comb begin
    stop_s       = inst_idle_sigs | inst_block_sigs | axis_block_sigs;
    cond_s       = (|axis_block_sigs) & (&stop_s);
    timer_cond_s = cond_s & (state_r != ST_DETECTED);
  end

  hls_deadlock_stall_timer #(
    .THRESHOLD (THRESHOLD)
  ) u_stall_timer (
    .clock  (clock),
    .reset  (reset),
    .cond   (timer_cond_s),
    .clear  (clear),
    .expire (expire_s)
  );

  // Monitor FSM with flag, snapshots and saturating event counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      block          <= 1'b0;
      block_proc_vec <= {NUM_PROC{1'b0}};
      block_axis_vec <= {NUM_PROC{1'b0}};
      event_count    <= {EVT_W{1'b0}};
    end else if (clear) begin
      state_r <= ST_IDLE;
      block   <= 1'b0;
    end else if (expire_s) begin
      state_r        <= ST_DETECTED;
      block          <= 1'b1;
      block_proc_vec <= axis_block_sigs | inst_block_sigs;
      block_axis_vec <= axis_block_sigs;
      if (event_count != {EVT_W{1'b1}}) begin
        event_count <= event_count + EVT_W'(1);
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r <= cond_s ? ST_ARMED : ST_IDLE;
        end
        ST_ARMED: begin
          state_r <= cond_s ? ST_ARMED : ST_IDLE;
        end
        ST_DETECTED: begin
          // Non-sticky flag follows the stall; snapshots keep their capture.
          if ((STICKY == 0) && !cond_s) begin
            state_r <= ST_IDLE;
            block   <= 1'b0;
          end else begin
            state_r <= ST_DETECTED;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          block   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hls_deadlock_monitor_param.sv
// Directed self-checking bench: three monitor configurations on shared stimulus.
module tb_hls_deadlock_monitor_param;

  logic       clock;
  logic       reset;
  logic [1:0] axis;
  logic [1:0] idle;
  logic [1:0] inst;
  logic       clear;

  logic       a_block, b_block, c_block;
  logic [1:0] a_proc, a_axis, b_proc, b_axis, c_proc, c_axis;
  logic [7:0] a_cnt, b_cnt;
  logic [1:0] c_cnt;

  int errors = 0;
  int checks = 0;

  hls_deadlock_monitor_param #(.NUM_PROC(2), .THRESHOLD(4), .STICKY(1), .EVT_W(8)) dut_a (
    .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle),
    .inst_block_sigs(inst), .clear(clear), .block(a_block), .block_proc_vec(a_proc),
    .block_axis_vec(a_axis), .event_count(a_cnt));

  hls_deadlock_monitor_param #(.NUM_PROC(2), .THRESHOLD(1), .STICKY(0), .EVT_W(8)) dut_b (
    .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle),
    .inst_block_sigs(inst), .clear(clear), .block(b_block), .block_proc_vec(b_proc),
    .block_axis_vec(b_axis), .event_count(b_cnt));

  hls_deadlock_monitor_param #(.NUM_PROC(2), .THRESHOLD(1), .STICKY(1), .EVT_W(2)) dut_c (
    .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle),
    .inst_block_sigs(inst), .clear(clear), .block(c_block), .block_proc_vec(c_proc),
    .block_axis_vec(c_axis), .event_count(c_cnt));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic [1:0] ax, input logic [1:0] id, input logic [1:0] ib);
    axis = ax;
    idle = id;
    inst = ib;
  endtask

  task automatic apply_reset();
    set_in(2'b00, 2'b00, 2'b00);
    clear = 1'b0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (a_block !== 1'b0) begin errors++; $display("FAIL reset_block got=%0h exp=0", a_block); end
    checks++; if (a_proc !== 2'b00) begin errors++; $display("FAIL reset_proc got=%0h exp=0", a_proc); end
    checks++; if (a_axis !== 2'b00) begin errors++; $display("FAIL reset_axis got=%0h exp=0", a_axis); end
    checks++; if (a_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got=%0h exp=0", a_cnt); end
    checks++; if (b_block !== 1'b0) begin errors++; $display("FAIL reset_b_block got=%0h exp=0", b_block); end
    checks++; if (c_cnt !== 2'd0) begin errors++; $display("FAIL reset_c_cnt got=%0h exp=0", c_cnt); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_detect_sticky();
    apply_reset();
    set_in(2'b01, 2'b10, 2'b00);
    repeat (3) tick();
    checks++; if (a_block !== 1'b0) begin errors++; $display("FAIL detect_early got=%0h exp=0", a_block); end
    tick();
    checks++; if (a_block !== 1'b1) begin errors++; $display("FAIL detect_block got=%0h exp=1", a_block); end
    checks++; if (a_axis !== 2'b01) begin errors++; $display("FAIL detect_axis got=%0h exp=1", a_axis); end
    checks++; if (a_proc !== 2'b01) begin errors++; $display("FAIL detect_proc got=%0h exp=1", a_proc); end
    checks++; if (a_cnt !== 8'd1) begin errors++; $display("FAIL detect_cnt got=%0h exp=1", a_cnt); end
    set_in(2'b00, 2'b00, 2'b00);
    repeat (2) tick();
    checks++; if (a_block !== 1'b1) begin errors++; $display("FAIL sticky_hold got=%0h exp=1", a_block); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (a_block !== 1'b0) begin errors++; $display("FAIL sticky_clear got=%0h exp=0", a_block); end
    checks++; if (a_axis !== 2'b01) begin errors++; $display("FAIL clear_keeps_axis got=%0h exp=1", a_axis); end
    set_in(2'b01, 2'b10, 2'b00);
    repeat (4) tick();
    checks++; if (a_block !== 1'b1) begin errors++; $display("FAIL redetect_block got=%0h exp=1", a_block); end
    checks++; if (a_cnt !== 8'd2) begin errors++; $display("FAIL redetect_cnt got=%0h exp=2", a_cnt); end
  endtask

  task automatic test_break();
    apply_reset();
    set_in(2'b01, 2'b10, 2'b00);
    repeat (3) tick();
    set_in(2'b01, 2'b00, 2'b00);
    tick();
    set_in(2'b01, 2'b10, 2'b00);
    repeat (3) tick();
    checks++; if (a_block !== 1'b0) begin errors++; $display("FAIL break_block got=%0h exp=0", a_block); end
    checks++; if (a_cnt !== 8'd0) begin errors++; $display("FAIL break_cnt got=%0h exp=0", a_cnt); end
    tick();
    checks++; if (a_block !== 1'b1) begin errors++; $display("FAIL break_fresh_run got=%0h exp=1", a_block); end
    checks++; if (a_cnt !== 8'd1) begin errors++; $display("FAIL break_fresh_cnt got=%0h exp=1", a_cnt); end
  endtask

  task automatic test_legacy();
    apply_reset();
    set_in(2'b11, 2'b00, 2'b00);
    tick();
    checks++; if (b_block !== 1'b1) begin errors++; $display("FAIL legacy_block got=%0h exp=1", b_block); end
    checks++; if (b_axis !== 2'b11) begin errors++; $display("FAIL legacy_axis got=%0h exp=3", b_axis); end
    checks++; if (b_proc !== 2'b11) begin errors++; $display("FAIL legacy_proc got=%0h exp=3", b_proc); end
    set_in(2'b00, 2'b00, 2'b00);
    tick();
    checks++; if (b_block !== 1'b0) begin errors++; $display("FAIL legacy_drop got=%0h exp=0", b_block); end
    checks++; if (b_axis !== 2'b11) begin errors++; $display("FAIL legacy_snap_hold got=%0h exp=3", b_axis); end
    set_in(2'b00, 2'b00, 2'b11);
    tick();
    checks++; if (b_block !== 1'b0) begin errors++; $display("FAIL legacy_no_axis got=%0h exp=0", b_block); end
    set_in(2'b01, 2'b00, 2'b00);
    tick();
    checks++; if (b_block !== 1'b0) begin errors++; $display("FAIL legacy_running got=%0h exp=0", b_block); end
    set_in(2'b01, 2'b00, 2'b10);
    tick();
    checks++; if (b_block !== 1'b1) begin errors++; $display("FAIL legacy_mixed got=%0h exp=1", b_block); end
    checks++; if (b_proc !== 2'b11) begin errors++; $display("FAIL legacy_mixed_proc got=%0h exp=3", b_proc); end
    checks++; if (b_axis !== 2'b01) begin errors++; $display("FAIL legacy_mixed_axis got=%0h exp=1", b_axis); end
    checks++; if (b_cnt !== 8'd2) begin errors++; $display("FAIL legacy_cnt got=%0h exp=2", b_cnt); end
  endtask

  task automatic test_clear_priority();
    apply_reset();
    set_in(2'b01, 2'b10, 2'b00);
    repeat (4) tick();
    set_in(2'b00, 2'b00, 2'b00);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    set_in(2'b10, 2'b01, 2'b00);
    repeat (3) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (a_block !== 1'b0) begin errors++; $display("FAIL prio_block got=%0h exp=0", a_block); end
    checks++; if (a_cnt !== 8'd1) begin errors++; $display("FAIL prio_cnt got=%0h exp=1", a_cnt); end
    checks++; if (a_axis !== 2'b01) begin errors++; $display("FAIL prio_axis got=%0h exp=1", a_axis); end
    checks++; if (a_proc !== 2'b01) begin errors++; $display("FAIL prio_proc got=%0h exp=1", a_proc); end
    repeat (3) tick();
    checks++; if (a_block !== 1'b0) begin errors++; $display("FAIL prio_restart got=%0h exp=0", a_block); end
    tick();
    checks++; if (a_block !== 1'b1) begin errors++; $display("FAIL prio_redetect got=%0h exp=1", a_block); end
    checks++; if (a_axis !== 2'b10) begin errors++; $display("FAIL prio_new_axis got=%0h exp=2", a_axis); end
    checks++; if (a_proc !== 2'b10) begin errors++; $display("FAIL prio_new_proc got=%0h exp=2", a_proc); end
    checks++; if (a_cnt !== 8'd2) begin errors++; $display("FAIL prio_new_cnt got=%0h exp=2", a_cnt); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      set_in(2'b01, 2'b10, 2'b00);
      tick();
      set_in(2'b00, 2'b00, 2'b00);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      exp_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
      checks++;
      if (c_cnt !== exp_cnt) begin
        errors++;
        $display("FAIL sat_cnt_%0d got=%0h exp=%0h", i, c_cnt, exp_cnt);
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    set_in(2'b01, 2'b10, 2'b00);
    repeat (4) tick();
    set_in(2'b00, 2'b00, 2'b00);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    set_in(2'b01, 2'b10, 2'b00);
    repeat (2) tick();
    #2;
    reset = 1'b1;
    #1;
    checks++; if (a_block !== 1'b0) begin errors++; $display("FAIL async_block got=%0h exp=0", a_block); end
    checks++; if (a_cnt !== 8'd0) begin errors++; $display("FAIL async_cnt got=%0h exp=0", a_cnt); end
    checks++; if (a_axis !== 2'b00) begin errors++; $display("FAIL async_axis got=%0h exp=0", a_axis); end
    checks++; if (a_proc !== 2'b00) begin errors++; $display("FAIL async_proc got=%0h exp=0", a_proc); end
    #1;
    reset = 1'b0;
    repeat (3) tick();
    checks++; if (a_block !== 1'b0) begin errors++; $display("FAIL async_restart got=%0h exp=0", a_block); end
    tick();
    checks++; if (a_block !== 1'b1) begin errors++; $display("FAIL async_redetect got=%0h exp=1", a_block); end
  endtask

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    set_in(2'b00, 2'b00, 2'b00);
    test_reset();
    test_detect_sticky();
    test_break();
    test_legacy();
    test_clear_priority();
    test_saturation();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
